// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB transmit serialiser (SYNC/PID/DATA/CRC16/EOP).
// Bit stuffing + NRZI. Optional underrun abort via USB_TX_UNDERRUN_EN.
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] tx_packet,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_data,
   output logic       dplus_out,
   output logic       dminus_out,
   output logic       tx_transfer_active,
   output logic       tx_done
`ifdef USB_TX_UNDERRUN_EN
   ,
   output logic       tx_error
`endif
);

   localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC,
      S_PID,
      S_DATA,
      S_CRC_LO,
      S_CRC_HI,
      S_EOP_SE0,
      S_EOP_J,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic [6:0]    rem_q, rem_d;
   logic          dpkt_q, dpkt_d;
   logic [3:0]    pid_q, pid_d;
   logic [15:0]   crc_q, crc_d;
   logic [2:0]    ones_q, ones_d;
   logic          stuff_q, stuff_d;
   logic          line_q, line_d;
   logic          dp_q, dp_d;
   logic          dm_q, dm_d;
   logic          active_q, active_d;
   logic          done_q, done_d;
   logic          get_q, get_d;
   logic          abort_q, abort_d;
`ifdef USB_TX_UNDERRUN_EN
   logic          err_q, err_d;
`endif

   logic [3:0]    pid_sel;
   logic          req_ok;
   logic          bit_end;
   logic          launch;
   logic          raw;
   logic          fetch;
   state_t        nxt_state;
   logic [7:0]    nxt_byte;
   logic [2:0]    nxt_bit;
   logic          nxt_stuff;
   logic [7:0]    head_byte;

   // request code to 4-bit PID
   always_comb begin
      pid_sel = 4'h0;
      unique case (tx_packet)
         3'd1:    pid_sel = 4'h3;
         3'd2:    pid_sel = 4'hB;
         3'd3:    pid_sel = 4'h2;
         3'd4:    pid_sel = 4'hA;
         3'd5:    pid_sel = 4'hE;
         default: pid_sel = 4'h0;
      endcase
   end

   // next-state, bit sequencing, stuffing, NRZI and fetch control
   always_comb begin
      state_d   = state_q;
      div_d     = '0;
      bit_d     = bit_q;
      shift_d   = shift_q;
      data_d    = data_q;
      rem_d     = rem_q;
      dpkt_d    = dpkt_q;
      pid_d     = pid_q;
      crc_d     = crc_q;
      ones_d    = ones_q;
      stuff_d   = stuff_q;
      line_d    = line_q;
      dp_d      = dp_q;
      dm_d      = dm_q;
      active_d  = active_q;
      done_d    = 1'b0;
      get_d     = 1'b0;
      abort_d   = abort_q;
`ifdef USB_TX_UNDERRUN_EN
      err_d     = 1'b0;
`endif
      nxt_state = state_q;
      nxt_byte  = shift_q;
      nxt_bit   = bit_q;
      nxt_stuff = 1'b0;
      launch    = 1'b0;
      fetch     = 1'b0;
      req_ok    = (tx_packet >= 3'd1) &&
                  (tx_packet <= 3'd5);
      bit_end   = (div_q == DIV_LAST);
      head_byte = get_q ? tx_packet_data
                        : data_q;
      if (get_q) data_d = tx_packet_data;

      unique case (state_q)
         S_IDLE: begin
            if (req_ok) begin
               pid_d     = pid_sel;
               dpkt_d    = (tx_packet <= 3'd2);
               rem_d     = (tx_packet <= 3'd2)
                           ? buffer_occupancy : '0;
               crc_d     = 16'hFFFF;
               abort_d   = 1'b0;
               active_d  = 1'b1;
               nxt_state = S_SYNC;
               nxt_byte  = 8'h80;
               nxt_bit   = 3'd0;
               launch    = 1'b1;
            end
         end
         S_SYNC, S_PID, S_DATA,
         S_CRC_LO, S_CRC_HI: begin
            div_d = bit_end ? '0 : div_q + 1'b1;
            if (bit_end) begin
               launch = 1'b1;
               if (!stuff_q && ones_q == 3'd6) begin
                  nxt_stuff = 1'b1;
               end else if (bit_q != 3'd7) begin
                  nxt_bit = bit_q + 3'd1;
               end else begin
                  nxt_bit = 3'd0;
                  unique case (state_q)
                     S_SYNC: begin
                        nxt_state = S_PID;
                        nxt_byte  = {~pid_q, pid_q};
                     end
                     S_PID, S_DATA: begin
                        if (abort_q) begin
                           nxt_state = S_EOP_SE0;
                        end else if (rem_q != '0) begin
                           nxt_state = S_DATA;
                           nxt_byte  = head_byte;
                           rem_d     = rem_q - 7'd1;
                        end else if (dpkt_q) begin
                           nxt_state = S_CRC_LO;
                           nxt_byte  = ~crc_q[7:0];
                        end else begin
                           nxt_state = S_EOP_SE0;
                        end
                     end
                     S_CRC_LO: begin
                        nxt_state = S_CRC_HI;
                        nxt_byte  = ~crc_q[15:8];
                     end
                     default: begin
                        nxt_state = S_EOP_SE0;
                     end
                  endcase
               end
            end
         end
         S_EOP_SE0: begin
            div_d = bit_end ? '0 : div_q + 1'b1;
            if (bit_end) begin
               if (bit_q == 3'd0) begin
                  bit_d = 3'd1;
               end else begin
                  state_d = S_EOP_J;
                  bit_d   = 3'd0;
                  line_d  = 1'b1;
                  dp_d    = 1'b1;
                  dm_d    = 1'b0;
               end
            end
         end
         S_EOP_J: begin
            div_d = bit_end ? '0 : div_q + 1'b1;
            if (bit_end) begin
               state_d  = S_DONE;
               active_d = 1'b0;
               done_d   = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      raw = nxt_stuff ? 1'b0 : nxt_byte[nxt_bit];

      if (launch && nxt_state == S_EOP_SE0) begin
         state_d = S_EOP_SE0;
         bit_d   = 3'd0;
         stuff_d = 1'b0;
         ones_d  = 3'd0;
         dp_d    = 1'b0;
         dm_d    = 1'b0;
      end else if (launch) begin
         state_d = nxt_state;
         bit_d   = nxt_bit;
         shift_d = nxt_byte;
         stuff_d = nxt_stuff;
         ones_d  = raw ? ones_q + 3'd1 : 3'd0;
         line_d  = raw ? line_q : ~line_q;
         dp_d    = line_d;
         dm_d    = ~line_d;
         if (nxt_state == S_DATA && !nxt_stuff) begin
            crc_d = (crc_q >> 1) ^
                    ((crc_q[0] ^ raw) ? 16'hA001
                                      : 16'h0000);
         end
         fetch = !nxt_stuff &&
                 (nxt_bit == 3'd7) &&
                 (nxt_state == S_PID ||
                  nxt_state == S_DATA) &&
                 (rem_q != '0) &&
                 !abort_q;
      end

      if (fetch) begin
`ifdef USB_TX_UNDERRUN_EN
         if (buffer_occupancy == '0) begin
            err_d   = 1'b1;
            abort_d = 1'b1;
         end else begin
            get_d = 1'b1;
         end
`else
         get_d = 1'b1;
`endif
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         bit_q    <= 3'd0;
         shift_q  <= 8'h00;
         data_q   <= 8'h00;
         rem_q    <= 7'd0;
         dpkt_q   <= 1'b0;
         pid_q    <= 4'h0;
         crc_q    <= 16'h0000;
         ones_q   <= 3'd0;
         stuff_q  <= 1'b0;
         line_q   <= 1'b1;
         dp_q     <= 1'b1;
         dm_q     <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         get_q    <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         rem_q    <= rem_d;
         dpkt_q   <= dpkt_d;
         pid_q    <= pid_d;
         crc_q    <= crc_d;
         ones_q   <= ones_d;
         stuff_q  <= stuff_d;
         line_q   <= line_d;
         dp_q     <= dp_d;
         dm_q     <= dm_d;
         active_q <= active_d;
         done_q   <= done_d;
         get_q    <= get_d;
         abort_q  <= abort_d;
      end
   end

`ifdef USB_TX_UNDERRUN_EN
   // underrun error pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign tx_error = err_q;
`endif

   assign get_tx_data        = get_q;
   assign dplus_out          = dp_q;
   assign dminus_out         = dm_q;
   assign tx_transfer_active = active_q;
   assign tx_done            = done_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: randomized + directed bench with a bit-level
// reference model (stuffing/NRZI from a byte list) and a line decoder.
module tb_usb_tx_encoder;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] tx_packet = 3'd0;
   logic [6:0] buffer_occupancy;
   logic [7:0] tx_packet_data;
   logic       get_tx_data;
   logic       dplus_out;
   logic       dminus_out;
   logic       tx_transfer_active;
   logic       tx_done;
`ifdef USB_TX_UNDERRUN_EN
   logic       tx_error;
   int         errs = 0;
`endif

   int passed = 0;
   int total  = 0;

   logic [7:0] mem [256];
   int wr = 0;
   int rd = 0;
   int gets = 0;
   int dones = 0;
   logic [1:0] wave [$];

   logic [7:0] payload [$];
   logic [7:0] exp_bytes [$];
   logic [1:0] exp_wave [$];
   logic [7:0] dec_bytes [$];
   int model_stuffs;
   int dec_stuffs;
   int dec_bad;
   logic mlvl;
   int mrun;

   usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
      .clk                (clk),
      .rst                (rst),
      .tx_packet          (tx_packet),
      .buffer_occupancy   (buffer_occupancy),
      .tx_packet_data     (tx_packet_data),
      .get_tx_data        (get_tx_data),
      .dplus_out          (dplus_out),
      .dminus_out         (dminus_out),
      .tx_transfer_active (tx_transfer_active),
      .tx_done            (tx_done)
`ifdef USB_TX_UNDERRUN_EN
      ,
      .tx_error           (tx_error)
`endif
   );

   always #5 clk = ~clk;

   assign buffer_occupancy = 7'(wr - rd);
   assign tx_packet_data   = (wr != rd) ? mem[8'(rd)] : 8'h00;

   // buffer pop on strobe
   always @(posedge clk)
      if (get_tx_data && wr != rd) rd <= rd + 1;

   // line and strobe monitor
   always @(negedge clk) begin
      if (tx_transfer_active)
         wave.push_back({dplus_out, dminus_out});
      if (get_tx_data) gets <= gets + 1;
      if (tx_done) dones <= dones + 1;
`ifdef USB_TX_UNDERRUN_EN
      if (tx_error) errs <= errs + 1;
`endif
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h",
                  tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [7:0] pid_byte(input logic [2:0] c);
      case (c)
         3'd1:    return 8'hC3;
         3'd2:    return 8'h4B;
         3'd3:    return 8'hD2;
         3'd4:    return 8'h5A;
         default: return 8'h1E;
      endcase
   endfunction

   function automatic logic [15:0] crc_of(input int n);
      logic [15:0] c;
      logic [7:0] by;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         by = payload[i];
         for (int k = 0; k < 8; k++)
            c = (c >> 1) ^ ((c[0] ^ by[k]) ? 16'hA001 : 16'h0);
      end
      return ~c;
   endfunction

   function automatic void emit_bit(input logic b);
      if (!b) mlvl = ~mlvl;
      for (int r = 0; r < CPB; r++)
         exp_wave.push_back({mlvl, ~mlvl});
   endfunction

   function automatic void build_wave();
      logic [7:0] by;
      exp_wave.delete();
      model_stuffs = 0;
      mlvl = 1'b1;
      mrun = 0;
      foreach (exp_bytes[i]) begin
         by = exp_bytes[i];
         for (int k = 0; k < 8; k++) begin
            emit_bit(by[k]);
            mrun = by[k] ? mrun + 1 : 0;
            if (mrun == 6) begin
               emit_bit(1'b0);
               mrun = 0;
               model_stuffs++;
            end
         end
      end
      for (int r = 0; r < 2 * CPB; r++) exp_wave.push_back(2'b00);
      for (int r = 0; r < CPB; r++) exp_wave.push_back(2'b10);
   endfunction

   function automatic void decode(input int s0);
      logic prev, b, skip;
      logic [1:0] sym;
      logic [7:0] acc;
      int run, nb;
      dec_bytes.delete();
      dec_stuffs = 0;
      dec_bad = 0;
      prev = 1'b1;
      skip = 1'b0;
      acc = 8'h00;
      run = 0;
      nb = 0;
      for (int k = s0 + 1; k < wave.size(); k += CPB) begin
         sym = wave[k];
         if (sym == 2'b00) break;
         b = (sym[1] == prev);
         prev = sym[1];
         if (skip) begin
            skip = 1'b0;
            dec_stuffs++;
            if (b) dec_bad++;
         end else begin
            acc[3'(nb)] = b;
            nb++;
            if (nb == 8) begin
               dec_bytes.push_back(acc);
               nb = 0;
            end
            run = b ? run + 1 : 0;
            if (run == 6) begin
               skip = 1'b1;
               run = 0;
            end
         end
      end
      if (nb != 0) dec_bad++;
   endfunction

   task automatic check_pkt(input string tag, input int s0);
      int mism, n;
      build_wave();
      chk({tag, "_len"}, 32'(wave.size() - s0), 32'(exp_wave.size()));
      mism = 0;
      n = wave.size() - s0;
      if (n > exp_wave.size()) n = exp_wave.size();
      for (int i = 0; i < n; i++)
         if (wave[s0 + i] !== exp_wave[i]) mism++;
      chk({tag, "_wave"}, 32'(mism), 32'd0);
      decode(s0);
      chk({tag, "_nbytes"}, 32'(dec_bytes.size()), 32'(exp_bytes.size()));
      mism = 0;
      foreach (dec_bytes[i])
         if (i < exp_bytes.size() && dec_bytes[i] !== exp_bytes[i]) mism++;
      chk({tag, "_bytes"}, 32'(mism), 32'd0);
      chk({tag, "_stuffs"}, 32'(dec_stuffs), 32'(model_stuffs));
      chk({tag, "_stuffbad"}, 32'(dec_bad), 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int cyc;
      cyc = 0;
      while (tx_done !== 1'b1 && cyc < 6000) begin
         step();
         cyc++;
      end
      chk({tag, "_done"}, 32'(tx_done), 32'd1);
   endtask

   // payload must be filled; returns in the idle cycle after tx_done
   task automatic send(input string tag, input logic [2:0] code,
                       input bit poke);
      int s0, g0, d0, n;
      logic [15:0] c;
      n = (code <= 3'd2) ? payload.size() : 0;
      for (int i = 0; i < n; i++) begin
         mem[8'(wr)] = payload[i];
         wr++;
      end
      exp_bytes.delete();
      exp_bytes.push_back(8'h80);
      exp_bytes.push_back(pid_byte(code));
      if (code <= 3'd2) begin
         for (int i = 0; i < n; i++) exp_bytes.push_back(payload[i]);
         c = crc_of(n);
         exp_bytes.push_back(c[7:0]);
         exp_bytes.push_back(c[15:8]);
      end
      s0 = wave.size();
      g0 = gets;
      d0 = dones;
      tx_packet = code;
      step();
      tx_packet = 3'd0;
      chk({tag, "_start"}, 32'({tx_transfer_active, dplus_out, dminus_out}),
          32'b101);
      wait_done(tag);
      if (poke) tx_packet = 3'd3;
      step();
      tx_packet = 3'd0;
      chk({tag, "_gets"}, 32'(gets - g0), 32'(n));
      chk({tag, "_once"}, 32'({dones - d0, tx_done}), 32'({1, 1'b0}));
      check_pkt(tag, s0);
      if (code == 3'd3)
         chk({tag, "_active76"}, 32'(wave.size() - s0), 32'd76);
      if (code <= 3'd2 && n == 0)
         chk({tag, "_bits32"}, 32'(wave.size() - s0), 32'(32 * CPB + 12));
   endtask

   initial begin
      int s0, g0, cnt;
      logic [2:0] code;

      // reset state
      step();
      chk("rst_lines", 32'({dplus_out, dminus_out}), 32'b10);
      chk("rst_ctl", 32'({get_tx_data, tx_transfer_active, tx_done}), 32'd0);
      rst = 1'b0;
      step();
      step();
      chk("idle_lines", 32'({dplus_out, dminus_out, tx_transfer_active}),
          32'b100);

      // handshakes
      payload.delete();
      send("ack", 3'd3, 1'b0);
      send("nak", 3'd4, 1'b0);
      send("stall", 3'd5, 1'b0);

      // zero-length DATA0
      send("d0_empty", 3'd1, 1'b0);

      // DATA1 01..04
      payload = '{8'h01, 8'h02, 8'h03, 8'h04};
      send("d1_four", 3'd2, 1'b0);

      // stuffing cases
      payload = '{8'hFF};
      send("ff_one", 3'd1, 1'b0);
      payload = '{8'hFF, 8'hFF, 8'hFF, 8'h7E};
      send("ff_run", 3'd2, 1'b0);

      // request during tx_done cycle is ignored
      payload.delete();
      send("poke", 3'd4, 1'b1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (tx_transfer_active) cnt++;
      end
      chk("done_ignored", 32'(cnt), 32'd0);

      // codes 6 and 7 are ignored
      tx_packet = 3'd6;
      step();
      tx_packet = 3'd7;
      step();
      tx_packet = 3'd0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (tx_transfer_active) cnt++;
      end
      chk("code67_ignored", 32'(cnt), 32'd0);

      // randomized packets
      for (int p = 0; p < 12; p++) begin
         code = 3'($urandom_range(1, 5));
         payload.delete();
         if (code <= 3'd2) begin
            cnt = (p == 0) ? 64 : $urandom_range(0, 20);
            for (int i = 0; i < cnt; i++)
               payload.push_back(($urandom_range(0, 3) == 0)
                                 ? 8'hFF : 8'($urandom));
         end
         send($sformatf("rnd%0d", p), code, 1'b0);
      end

      // async reset mid-SYNC
      payload = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
         mem[8'(wr)] = payload[i];
         wr++;
      end
      tx_packet = 3'd1;
      step();
      tx_packet = 3'd0;
      step();
      step();
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_lines",
          32'({dplus_out, dminus_out, tx_transfer_active}), 32'b100);
      step();
      rst = 1'b0;
      g0 = gets;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx_transfer_active) cnt++;
      end
      chk("mid_rst_gets", 32'(gets - g0), 32'd0);
      chk("mid_rst_quiet", 32'(cnt), 32'd0);
      wr = rd;
      step();

      // packet after reset recovery
      payload = '{8'hA5, 8'h5A};
      send("post_rst", 3'd1, 1'b0);

`ifdef USB_TX_UNDERRUN_EN
      // underrun: two bytes latched, buffer flushed after first pop
      begin
         int e0;
         payload = '{8'hC8, 8'h37};
         for (int i = 0; i < 2; i++) begin
            mem[8'(wr)] = payload[i];
            wr++;
         end
         exp_bytes = '{8'h80, 8'hC3, 8'hC8};
         s0 = wave.size();
         g0 = gets;
         e0 = errs;
         tx_packet = 3'd1;
         step();
         tx_packet = 3'd0;
         cnt = 0;
         while (gets == g0 && cnt < 400) begin
            step();
            cnt++;
         end
         chk("udr_first_get", 32'(gets - g0), 32'd1);
         step();
         wr = rd;
         wait_done("udr");
         step();
         chk("udr_gets", 32'(gets - g0), 32'd1);
         chk("udr_err", 32'(errs - e0), 32'd1);
         check_pkt("udr", s0);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
